// File: rtl/ldvio_ctrl_if.sv
// Request/write-port bundle for the load-violation RAM write controller.
// The master drives violation and clear requests; the slave (the controller) owns the RAM write port.
interface ldvio_ctrl_if #(
    parameter int unsigned INDEX = 4,
    parameter int unsigned WIDTH = 8
);
    logic             viol_valid_i;
    logic [INDEX-1:0] viol_idx_i;
    logic [WIDTH-1:0] viol_data_i;
    logic             viol_ready_o;
    logic             clr_valid_i;
    logic [INDEX-1:0] clr_idx_i;
    logic             busy_o;
    logic             viol_pending_o;
    logic             we0_o;
    logic [INDEX-1:0] addr0wr_o;
    logic [WIDTH-1:0] data0wr_o;

    modport master (
        output viol_valid_i, viol_idx_i, viol_data_i, clr_valid_i, clr_idx_i,
        input  viol_ready_o, busy_o, viol_pending_o, we0_o, addr0wr_o, data0wr_o
    );

    modport slave (
        input  viol_valid_i, viol_idx_i, viol_data_i, clr_valid_i, clr_idx_i,
        output viol_ready_o, busy_o, viol_pending_o, we0_o, addr0wr_o, data0wr_o
    );
endinterface

// File: rtl/ldvio_ctrl.sv
// Load-violation RAM write-port controller: zeroing sweep after reset/flush, then
// arbitrates commit clears (priority) against a small queue of LSU violation writes.
module ldvio_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned INDEX  = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned QDEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    input logic         flush_i,
    ldvio_ctrl_if.slave bus
);
    typedef enum logic {SWEEP, IDLE} state_t;

    localparam int unsigned QPW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [INDEX-1:0] LAST  = INDEX'(DEPTH - 1);
    localparam logic [QPW:0]     QFULL = (QPW + 1)'(QDEPTH);

    state_t state, state_d;

    logic [INDEX-1:0] ptr, ptr_d;
    logic [QPW-1:0]   head, tail;
    logic [QPW:0]     count;
    logic [QDEPTH-1:0] q_valid;
    logic [INDEX-1:0] q_idx  [QDEPTH];
    logic [WIDTH-1:0] q_data [QDEPTH];

    logic             ready, clr_acc, push, pop;
    logic             wr_en_d;
    logic [INDEX-1:0] wr_addr_d;
    logic [WIDTH-1:0] wr_data_d;
    logic             we0_q;
    logic [INDEX-1:0] addr_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SWEEP;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (flush_i) begin
            state_d = SWEEP;
        end else if (state == SWEEP && ptr == LAST) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ready   = (state == IDLE) && !flush_i && (count < QFULL);
        clr_acc = (state == IDLE) && !flush_i && bus.clr_valid_i;
        // A violation aimed at the entry being cleared is handshaked but never stored.
        push    = bus.viol_valid_i && ready &&
                  !(clr_acc && (bus.viol_idx_i == bus.clr_idx_i));
        pop     = (state == IDLE) && !flush_i && !bus.clr_valid_i && (count != '0);

        ptr_d     = ptr;
        wr_en_d   = 1'b0;
        wr_addr_d = addr_q;
        wr_data_d = data_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (state == SWEEP) begin
            ptr_d     = ptr + 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = ptr;
            wr_data_d = '0;
        end else if (clr_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.clr_idx_i;
            wr_data_d = '0;
        end else if (pop && q_valid[head]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = q_idx[head];
            wr_data_d = q_data[head];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
            we0_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ptr    <= ptr_d;
            we0_q  <= wr_en_d;
            addr_q <= wr_addr_d;
            data_q <= wr_data_d;
            if (flush_i) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                q_valid <= '0;
            end else begin
                // Killed entries stay in the queue as holes so count and ordering are unchanged.
                if (clr_acc) begin
                    for (int unsigned i = 0; i < QDEPTH; i++) begin
                        if (q_idx[i] == bus.clr_idx_i) begin
                            q_valid[i] <= 1'b0;
                        end
                    end
                end
                if (push) begin
                    q_valid[tail] <= 1'b1;
                    tail          <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= bus.viol_idx_i;
            q_data[tail] <= bus.viol_data_i;
        end
    end

    assign bus.viol_ready_o   = ready;
    assign bus.busy_o         = (state == SWEEP) || flush_i;
    assign bus.viol_pending_o = (count != '0);
    assign bus.we0_o          = we0_q;
    assign bus.addr0wr_o      = addr_q;
    assign bus.data0wr_o      = data_q;
endmodule

// File: tb/tb_ldvio_ctrl.sv
// Scoreboard bench for ldvio_ctrl: a queue-based reference model predicts each RAM write
// and its cycle; a negedge monitor pops and compares whenever we0_o is high.
module tb_ldvio_ctrl;
    localparam int DEPTH  = 16;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush_i;

    always #5 clk = ~clk;

    ldvio_ctrl_if #(.INDEX(4), .WIDTH(8)) bus ();

    ldvio_ctrl #(.DEPTH(DEPTH), .INDEX(4), .WIDTH(8), .QDEPTH(QDEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .flush_i(flush_i),
        .bus    (bus)
    );

    typedef struct {int cyc; int addr; int data;} wr_t;
    typedef struct {bit v; int idx; int data;} ent_t;

    wr_t  exp_q[$];
    ent_t mq[$];
    int   sw_left;
    int   cyc;
    int   tests = 0;
    int   fails = 0;
    bit   running = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (running) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_write cyc=%0d actual=none required=addr %0d data %0d at cyc %0d",
                         cyc, e.addr, e.data, e.cyc);
            end
            if (bus.we0_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write cyc=%0d actual=addr %0d data %0d required=no write",
                             cyc, bus.addr0wr_o, bus.data0wr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cyc", cyc, e.cyc);
                    check("wr_addr", int'(bus.addr0wr_o), e.addr);
                    check("wr_data", int'(bus.data0wr_o), e.data);
                end
            end
        end
    end

    // One clock cycle: drive, compare status outputs, advance the reference model.
    task automatic step(input bit fl, input bit vv, input int vi, input int vd,
                        input bit cv, input int ci);
        bit   sweeping, m_busy, m_ready, m_pend;
        ent_t h;
        flush_i          = fl;
        bus.viol_valid_i = vv;
        bus.viol_idx_i   = 4'(vi);
        bus.viol_data_i  = 8'(vd);
        bus.clr_valid_i  = cv;
        bus.clr_idx_i    = 4'(ci);
        #1;
        sweeping = (sw_left > 0);
        m_busy   = sweeping || fl;
        m_ready  = !sweeping && !fl && (mq.size() < QDEPTH);
        m_pend   = (mq.size() != 0);
        check("busy", int'(bus.busy_o), int'(m_busy));
        check("ready", int'(bus.viol_ready_o), int'(m_ready));
        check("pending", int'(bus.viol_pending_o), int'(m_pend));
        if (fl) begin
            mq.delete();
            sw_left = DEPTH;
        end else if (sweeping) begin
            exp_q.push_back('{cyc + 1, DEPTH - sw_left, 0});
            sw_left--;
        end else if (cv) begin
            exp_q.push_back('{cyc + 1, ci, 0});
            foreach (mq[i]) if (mq[i].idx == ci) mq[i].v = 1'b0;
            if (vv && m_ready && vi != ci) mq.push_back('{1'b1, vi, vd});
        end else begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.v) exp_q.push_back('{cyc + 1, h.idx, h.data});
            end
            if (vv && m_ready) mq.push_back('{1'b1, vi, vd});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        reset            = 1'b1;
        flush_i          = 1'b0;
        bus.viol_valid_i = 1'b0;
        bus.viol_idx_i   = '0;
        bus.viol_data_i  = '0;
        bus.clr_valid_i  = 1'b0;
        bus.clr_idx_i    = '0;
        cyc              = 0;
        sw_left          = DEPTH;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", int'(bus.we0_o), 0);
        check("rst_addr", int'(bus.addr0wr_o), 0);
        check("rst_data", int'(bus.data0wr_o), 0);
        check("rst_pending", int'(bus.viol_pending_o), 0);
        reset   = 1'b0;
        running = 1'b1;

        // Sweep after reset, with violations and clears offered throughout.
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 8 + i % 8, $urandom_range(0, 255), 1'(i % 2), $urandom_range(0, 15));
        idle(6);

        // Single violation.
        step(1'b0, 1'b1, 5, 'hA3, 1'b0, 0);
        idle(4);

        // Contention between queued violations and back-to-back clears.
        step(1'b0, 1'b1, 1, 'h11, 1'b0, 0);
        step(1'b0, 1'b1, 2, 'h22, 1'b1, 7);
        step(1'b0, 1'b0, 0, 0, 1'b1, 8);
        idle(6);

        // Kill: queue {3,4,3}, then clear 3 with a same-cycle violation to 3.
        step(1'b0, 1'b1, 3, 'h31, 1'b1, 9);
        step(1'b0, 1'b1, 4, 'h41, 1'b1, 9);
        step(1'b0, 1'b1, 3, 'h32, 1'b1, 9);
        step(1'b0, 1'b1, 3, 'h33, 1'b1, 3);
        idle(6);

        // Backpressure under a continuous clear stream, then release.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 10 + i % 4, 'h50 + i, 1'b1, 9);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 14, 'h60 + i, 1'b0, 0);
        idle(8);

        // Flush in IDLE with three queued entries.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1 + i, 'h70 + i, 1'b1, 12);
        step(1'b1, 1'b1, 6, 'h7F, 1'b1, 12);
        // Flush at sweep cycle 7.
        idle(7);
        step(1'b1, 1'b0, 0, 0, 1'b0, 0);
        idle(20);

        // Randomized traffic with a narrow index range to provoke kills.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 $urandom_range(0, 255), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 7));
        idle(30);

        check("leftover_writes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
